// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register: 2-entry skid buffer carrying a control and a data bundle
// over valid/ready, with synchronous flush, selectable data-clear policy and a stall counter.
module pipe_stage_elastic #(
    parameter int CTRL_W   = 16,
    parameter int DATA_W   = 128,
    parameter bit CLR_DATA = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occ,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t              state_r;
    state_t              state_nx_s;
    logic [CTRL_W-1:0]   main_ctrl_r;
    logic [DATA_W-1:0]   main_data_r;
    logic [CTRL_W-1:0]   skid_ctrl_r;
    logic [DATA_W-1:0]   skid_data_r;
    logic [CNT_W-1:0]    stall_cnt_r;
    logic                push_s;
    logic                pop_s;
    logic                stall_s;
    logic                main_from_in_s;
    logic                main_from_skid_s;
    logic                skid_from_in_s;

    // Handshake terms see only registered state and the kill inputs, never the opposite side.
    assign in_ready  = (state_r != FULL) & ~flush & ~rst;
    assign out_valid = (state_r != EMPTY) & ~flush & ~rst;
    assign push_s    = in_valid & in_ready;
    assign pop_s     = out_valid & out_ready;
    assign stall_s   = out_valid & ~out_ready;

    assign out_ctrl  = main_ctrl_r;
    assign out_data  = main_data_r;
    assign occ       = state_r;
    assign stall_cnt = stall_cnt_r;

    // Occupancy next-state and register load selects.
    always_comb begin
        state_nx_s       = state_r;
        main_from_in_s   = 1'b0;
        main_from_skid_s = 1'b0;
        skid_from_in_s   = 1'b0;
        case (state_r)
            EMPTY: begin
                if (push_s) begin
                    state_nx_s     = ONE;
                    main_from_in_s = 1'b1;
                end else begin
                    state_nx_s = EMPTY;
                end
            end
            ONE: begin
                if (push_s && pop_s) begin
                    main_from_in_s = 1'b1;
                end else if (push_s) begin
                    state_nx_s     = FULL;
                    skid_from_in_s = 1'b1;
                end else if (pop_s) begin
                    state_nx_s = EMPTY;
                end else begin
                    state_nx_s = ONE;
                end
            end
            FULL: begin
                // Skid drains into main first so a later push can never overtake it.
                if (pop_s) begin
                    state_nx_s       = ONE;
                    main_from_skid_s = 1'b1;
                end else begin
                    state_nx_s = FULL;
                end
            end
            default: begin
                state_nx_s = EMPTY;
            end
        endcase
    end

    // State and payload registers with reset/flush kill.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= EMPTY;
            main_ctrl_r <= '0;
            main_data_r <= '0;
            skid_ctrl_r <= '0;
            skid_data_r <= '0;
        end else if (flush) begin
            state_r     <= EMPTY;
            main_ctrl_r <= '0;
            skid_ctrl_r <= '0;
            if (CLR_DATA) begin
                main_data_r <= '0;
                skid_data_r <= '0;
            end else begin
                main_data_r <= main_data_r;
                skid_data_r <= skid_data_r;
            end
        end else begin
            state_r <= state_nx_s;
            if (main_from_in_s) begin
                main_ctrl_r <= in_ctrl;
                main_data_r <= in_data;
            end else if (main_from_skid_s) begin
                main_ctrl_r <= skid_ctrl_r;
                main_data_r <= skid_data_r;
            end else begin
                main_ctrl_r <= main_ctrl_r;
                main_data_r <= main_data_r;
            end
            if (skid_from_in_s) begin
                skid_ctrl_r <= in_ctrl;
                skid_data_r <= in_data;
            end else begin
                skid_ctrl_r <= skid_ctrl_r;
                skid_data_r <= skid_data_r;
            end
        end
    end

    // Saturating stall counter; survives flush, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= '0;
        end else if (stall_s && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench: three instances (clear-data, hold-data, 4-bit counter) share one stimulus stream.
module tb_pipe_stage_elastic;

    localparam int CW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, out_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;

    logic          a_in_ready, a_out_valid, b_in_ready, b_out_valid, c_in_ready, c_out_valid;
    logic [CW-1:0] a_out_ctrl, b_out_ctrl, c_out_ctrl;
    logic [DW-1:0] a_out_data, b_out_data, c_out_data;
    logic [1:0]    a_occ, b_occ, c_occ;
    logic [15:0]   a_stall, b_stall;
    logic [3:0]    c_stall;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .CLR_DATA(1'b1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_ctrl(a_out_ctrl), .out_data(a_out_data), .occ(a_occ), .stall_cnt(a_stall));

    pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .CLR_DATA(1'b0), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_ctrl(b_out_ctrl), .out_data(b_out_data), .occ(b_occ), .stall_cnt(b_stall));

    pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .CLR_DATA(1'b1), .CNT_W(4)) dut_c (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(c_out_valid), .out_ready(out_ready),
        .out_ctrl(c_out_ctrl), .out_data(c_out_data), .occ(c_occ), .stall_cnt(c_stall));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
        in_valid = v;
        in_ctrl  = c;
        in_data  = d;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        offer(1'b0, 8'h00, 32'h0);

        // Reset values
        tick(); tick();
        check("rst_in_ready", a_in_ready, 1'b0);
        check("rst_out_valid", a_out_valid, 1'b0);
        check("rst_occ", a_occ, 2'd0);
        check("rst_ctrl", a_out_ctrl, 8'h00);
        check("rst_data", a_out_data, 32'h0);
        check("rst_stall", a_stall, 16'd0);
        rst = 1'b0;
        #1;
        check("rel_in_ready", a_in_ready, 1'b1);

        // Streaming 1..8 with out_ready high
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            offer(1'b1, CW'(i), 32'h1000 + 32'(i));
            tick();
            check("str_valid", a_out_valid, 1'b1);
            check("str_ctrl", a_out_ctrl, CW'(i));
            check("str_data", a_out_data, 32'h1000 + 32'(i));
            check("str_occ", a_occ, 2'd1);
        end
        offer(1'b0, 8'h00, 32'h0);
        tick();
        check("str_drain_valid", a_out_valid, 1'b0);
        check("str_drain_occ", a_occ, 2'd0);
        check("str_stall", a_stall, 16'd0);

        // Backpressure A, B, C
        out_ready = 1'b0;
        offer(1'b1, 8'hA1, 32'hAAAA);
        tick();
        check("bp_a_occ", a_occ, 2'd1);
        check("bp_a_ctrl", a_out_ctrl, 8'hA1);
        check("bp_a_stall", a_stall, 16'd0);
        offer(1'b1, 8'hB2, 32'hBBBB);
        tick();
        check("bp_b_occ", a_occ, 2'd2);
        check("bp_b_ctrl", a_out_ctrl, 8'hA1);
        check("bp_b_stall", a_stall, 16'd1);
        offer(1'b1, 8'hC3, 32'hCCCC);
        #1;
        check("bp_c_in_ready", a_in_ready, 1'b0);
        tick();
        check("bp_c_occ", a_occ, 2'd2);
        check("bp_c_ctrl", a_out_ctrl, 8'hA1);
        check("bp_c_stall", a_stall, 16'd2);
        out_ready = 1'b1;
        tick();
        check("bp_out_b_ctrl", a_out_ctrl, 8'hB2);
        check("bp_out_b_data", a_out_data, 32'hBBBB);
        check("bp_out_b_occ", a_occ, 2'd1);
        check("bp_out_b_stall", a_stall, 16'd2);
        tick();
        check("bp_out_c_ctrl", a_out_ctrl, 8'hC3);
        check("bp_out_c_occ", a_occ, 2'd1);
        offer(1'b0, 8'h00, 32'h0);
        tick();
        check("bp_end_valid", a_out_valid, 1'b0);

        // Flush while FULL
        out_ready = 1'b0;
        offer(1'b1, 8'hD1, 32'hD0D0);
        tick();
        offer(1'b1, 8'hE2, 32'hE0E0);
        tick();
        check("fl_pre_occ", a_occ, 2'd2);
        check("fl_pre_stall", b_stall, 16'd3);
        flush = 1'b1;
        offer(1'b1, 8'hF3, 32'hF0F0);
        #1;
        check("fl_in_ready", a_in_ready, 1'b0);
        check("fl_out_valid", a_out_valid, 1'b0);
        tick();
        flush = 1'b0;
        offer(1'b0, 8'h00, 32'h0);
        #1;
        check("fl_a_occ", a_occ, 2'd0);
        check("fl_a_valid", a_out_valid, 1'b0);
        check("fl_a_ctrl", a_out_ctrl, 8'h00);
        check("fl_a_data", a_out_data, 32'h0);
        check("fl_a_in_ready", a_in_ready, 1'b1);
        check("fl_b_ctrl", b_out_ctrl, 8'h00);
        check("fl_b_data", b_out_data, 32'hD0D0);
        check("fl_b_stall", b_stall, 16'd3);
        out_ready = 1'b1;
        tick();
        check("fl_no_ghost", a_out_valid, 1'b0);
        check("fl_no_ghost_b", b_out_valid, 1'b0);

        // Build occ=2, stall=37, then reset mid-operation
        out_ready = 1'b0;
        offer(1'b1, 8'h11, 32'h1111);
        tick();
        offer(1'b1, 8'h22, 32'h2222);
        tick();
        offer(1'b0, 8'h00, 32'h0);
        for (int i = 0; i < 33; i++) tick();
        check("pre_rst_occ", a_occ, 2'd2);
        check("pre_rst_stall", a_stall, 16'd37);
        check("sat_stall", c_stall, 4'd15);
        tick();
        check("sat_hold", c_stall, 4'd15);
        check("pre_rst_stall2", a_stall, 16'd38);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst_occ", a_occ, 2'd0);
        check("mid_rst_valid", a_out_valid, 1'b0);
        check("mid_rst_ctrl", a_out_ctrl, 8'h00);
        check("mid_rst_data_b", b_out_data, 32'h0);
        check("mid_rst_stall", a_stall, 16'd0);
        check("mid_rst_stall_c", c_stall, 4'd0);
        check("mid_rst_in_ready", a_in_ready, 1'b1);
        out_ready = 1'b1;
        offer(1'b1, 8'h5A, 32'h5A5A);
        #1;
        check("post_rst_pre_valid", a_out_valid, 1'b0);
        tick();
        check("post_rst_valid", a_out_valid, 1'b1);
        check("post_rst_ctrl", a_out_ctrl, 8'h5A);
        offer(1'b0, 8'h00, 32'h0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
